// File: rtl/scv_pkg.sv
//==============================================================================
// Module      : scv_pkg
// Description : Shared types and constants for the ROM-init download loader:
//               channel index type, well-known channel numbers, loader FSM
//               state encoding and a small index range helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package scv_pkg;

    // Channel index width; the loader supports at most eight channels.
    localparam int C_IDX_W   = 3;
    localparam int C_CKSUM_W = 16;

    typedef logic [C_IDX_W-1:0] rominit_idx_t;

    localparam rominit_idx_t ROMIDX_BOOT = 3'd0;
    localparam rominit_idx_t ROMIDX_CHR  = 3'd1;
    localparam rominit_idx_t ROMIDX_APU  = 3'd2;
    localparam rominit_idx_t ROMIDX_CART = 3'd3;

    // Loader FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SKIP = 2'd2,
        ST_FIN  = 2'd3
    } rominit_state_t;

    // True when a download index addresses one of the implemented channels.
    function automatic logic idx_in_range(input logic [7:0] idx, input int nch);
        return (int'(idx) < nch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rominit_chan.sv
//==============================================================================
// Module      : rominit_chan
// Description : Per-channel byte counter with saturation at the channel
//               capacity, sticky overflow flag and (when ROMINIT_CHECKSUM_EN
//               is defined) a mod-2^16 running checksum of accepted bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rominit_chan
    import scv_pkg::*;
#(
    parameter int          ADDR_W = 25,
    parameter int unsigned MAX    = 32'd33554432
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_wr,
    output logic              o_accept,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_overflow
`ifdef ROMINIT_CHECKSUM_EN
    ,
    input  logic [7:0]           i_data,
    output logic [C_CKSUM_W-1:0] o_cksum
`endif
);

    // One extra bit so the counter can hold a capacity of exactly 2**ADDR_W.
    localparam int                C_CNT_W = ADDR_W + 1;
    localparam logic [C_CNT_W-1:0] C_MAX  = C_CNT_W'(MAX);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_overflow;
    logic               w_full;

    assign w_full     = (r_cnt == C_MAX);
    assign o_accept   = i_wr & ~w_full;
    assign o_addr     = r_cnt[ADDR_W-1:0];
    assign o_overflow = r_overflow;

    // Byte counter: restarts at each load, saturates at capacity and flags
    // any byte that arrives once the channel is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (i_start) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (i_wr) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef ROMINIT_CHECKSUM_EN
    logic [C_CKSUM_W-1:0] r_cksum;

    assign o_cksum = r_cksum;

    // Running sum of accepted bytes only; dropped bytes do not contribute.
    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_cksum <= '0;
        end else if (o_accept) begin
            r_cksum <= r_cksum + C_CKSUM_W'(i_data);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/rominit_loader.sv
//==============================================================================
// Module      : rominit_loader
// Description : Routes a byte-serial download stream into one of NCH ROM
//               channels. Each download selects a channel by index, writes
//               bytes at incrementing addresses one cycle after each strobe,
//               drops bytes beyond the channel capacity and records sticky
//               per-channel LOADED / OVERFLOW flags. Out-of-range indices are
//               consumed silently.
//               Optional feature macro: ROMINIT_CHECKSUM_EN adds the CKSUM
//               output with a per-channel mod-2^16 byte sum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rominit_loader
    import scv_pkg::*;
#(
    parameter int          NCH            = 4,
    parameter int          ADDR_W         = 25,
    parameter int unsigned MAX_SIZE [NCH] = '{default: 2**ADDR_W}
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              DL_ACTIVE,
    input  logic [7:0]        DL_INDEX,
    input  logic              DL_WR,
    input  logic [7:0]        DL_DATA,
    output logic [NCH-1:0]    ROMINIT_SEL,
    output logic [ADDR_W-1:0] ROMINIT_ADDR,
    output logic [7:0]        ROMINIT_DATA,
    output logic              ROMINIT_VALID,
    output logic [NCH-1:0]    LOADED,
    output logic [NCH-1:0]    OVERFLOW,
    output logic              BUSY
`ifdef ROMINIT_CHECKSUM_EN
    ,
    output logic [NCH-1:0][C_CKSUM_W-1:0] CKSUM
`endif
);

    rominit_state_t    r_state;
    rominit_state_t    w_state_nxt;

    logic              r_act_q;
    logic [NCH-1:0]    r_sel;
    logic [NCH-1:0]    r_loaded;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;

    logic              w_rise;
    logic              w_start;
    logic              w_load_wr;
    logic              w_any_acc;
    logic [NCH-1:0]    w_new_oh;
    logic [NCH-1:0]    w_acc;
    logic [NCH-1:0]    w_ovf;
    logic [ADDR_W-1:0] w_chan_addr [NCH];
    logic [ADDR_W-1:0] w_cur_addr;

    // r_act_q resets high so a download still in progress across reset is
    // not mistaken for a fresh start; only a new low-to-high edge counts.
    assign w_rise    = DL_ACTIVE & ~r_act_q;
    assign w_load_wr = (r_state == ST_LOAD) & DL_WR;
    assign w_any_acc = |w_acc;

    assign ROMINIT_SEL   = r_sel;
    assign ROMINIT_ADDR  = r_addr;
    assign ROMINIT_DATA  = r_data;
    assign ROMINIT_VALID = r_valid;
    assign LOADED        = r_loaded;
    assign OVERFLOW      = w_ovf;
    assign BUSY          = (r_state != ST_IDLE);

    // One-hot decode of the requested channel.
    always_comb begin
        w_new_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            w_new_oh[i] = (DL_INDEX == 8'(i));
        end
    end

    // Current write address comes from whichever channel is selected.
    always_comb begin
        w_cur_addr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_sel[i]) begin
                w_cur_addr = w_chan_addr[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start on a rising DL_ACTIVE, end on its fall.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (idx_in_range(DL_INDEX, NCH)) begin
                        w_state_nxt = ST_LOAD;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_SKIP;
                    end
                end
            end
            ST_LOAD: begin
                if (!DL_ACTIVE) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_SKIP: begin
                if (!DL_ACTIVE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Channel select and completion flags. SEL is latched at load start and
    // kept through FIN so the final write (accepted on the falling cycle)
    // still appears with its channel selected; it clears as FIN completes.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_act_q  <= 1'b1;
            r_sel    <= '0;
            r_loaded <= '0;
        end else begin
            r_act_q <= DL_ACTIVE;
            if (w_start) begin
                r_sel <= w_new_oh;
            end else if (r_state == ST_FIN) begin
                r_sel    <= '0;
                r_loaded <= r_loaded | r_sel;
            end
        end
    end

    // Write port: one registered write per accepted byte, one cycle later.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_any_acc;
            if (w_any_acc) begin
                r_addr <= w_cur_addr;
                r_data <= DL_DATA;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        rominit_chan #(
            .ADDR_W (ADDR_W),
            .MAX    (MAX_SIZE[gi])
        ) u_chan (
            .clk        (CLK),
            .rst        (RES),
            .i_start    (w_start & w_new_oh[gi]),
            .i_wr       (w_load_wr & r_sel[gi]),
            .o_accept   (w_acc[gi]),
            .o_addr     (w_chan_addr[gi]),
            .o_overflow (w_ovf[gi])
`ifdef ROMINIT_CHECKSUM_EN
            ,
            .i_data     (DL_DATA),
            .o_cksum    (CKSUM[gi])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_rominit_loader.sv
//==============================================================================
// Module      : tb_rominit_loader
// Description : Scoreboard bench for rominit_loader. Download tasks push the
//               expected writes into a queue; a negedge monitor pops and
//               compares every ROMINIT_VALID. Flags are checked directly.
//               Define ROMINIT_CHECKSUM_EN to also exercise CKSUM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rominit_loader;
    import scv_pkg::*;

    localparam int          NCH_TB = 4;
    localparam int          AW     = 25;
    localparam int unsigned TB_MAX [NCH_TB] = '{32'd33554432, 32'd33554432, 32'd8, 32'd33554432};

    typedef struct {
        logic [NCH_TB-1:0] sel;
        logic [AW-1:0]     addr;
        logic [7:0]        data;
    } exp_t;

    logic              CLK;
    logic              RES;
    logic              DL_ACTIVE;
    logic [7:0]        DL_INDEX;
    logic              DL_WR;
    logic [7:0]        DL_DATA;
    logic [NCH_TB-1:0] ROMINIT_SEL;
    logic [AW-1:0]     ROMINIT_ADDR;
    logic [7:0]        ROMINIT_DATA;
    logic              ROMINIT_VALID;
    logic [NCH_TB-1:0] LOADED;
    logic [NCH_TB-1:0] OVERFLOW;
    logic              BUSY;
`ifdef ROMINIT_CHECKSUM_EN
    logic [NCH_TB-1:0][15:0] cksum;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    logic [7:0] pat [0:299];

    rominit_loader #(
        .NCH      (NCH_TB),
        .ADDR_W   (AW),
        .MAX_SIZE (TB_MAX)
    ) dut (
        .CLK           (CLK),
        .RES           (RES),
        .DL_ACTIVE     (DL_ACTIVE),
        .DL_INDEX      (DL_INDEX),
        .DL_WR         (DL_WR),
        .DL_DATA       (DL_DATA),
        .ROMINIT_SEL   (ROMINIT_SEL),
        .ROMINIT_ADDR  (ROMINIT_ADDR),
        .ROMINIT_DATA  (ROMINIT_DATA),
        .ROMINIT_VALID (ROMINIT_VALID),
        .LOADED        (LOADED),
        .OVERFLOW      (OVERFLOW),
        .BUSY          (BUSY)
`ifdef ROMINIT_CHECKSUM_EN
        ,
        .CKSUM         (cksum)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every write must match the oldest expected write.
    always @(negedge CLK) begin
        if (ROMINIT_VALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got sel=%b addr=%0h data=%0h, required no write",
                         ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA} !== {mon_e.sel, mon_e.addr, mon_e.data}) begin
                    failures++;
                    $display("FAIL write: got sel=%b addr=%0h data=%0h, required sel=%b addr=%0h data=%0h",
                             ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, mon_e.sel, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One full download of n bytes from pat[]; the last byte may be strobed
    // in the same cycle DL_ACTIVE falls.
    task automatic download(input int idx, input int n, input bit wr_on_fall);
        int cnt;
        exp_t e;
        cnt       = 0;
        DL_INDEX  = 8'(idx);
        DL_ACTIVE = 1'b1;
        tick();
        tick();
        for (int k = 0; k < n; k++) begin
            if (wr_on_fall && (k == n - 1)) DL_ACTIVE = 1'b0;
            DL_WR   = 1'b1;
            DL_DATA = pat[k];
            if (idx < NCH_TB) begin
                if (cnt < int'(TB_MAX[idx])) begin
                    e.sel  = NCH_TB'(1 << idx);
                    e.addr = AW'(cnt);
                    e.data = pat[k];
                    exp_q.push_back(e);
                    cnt++;
                end
            end else begin
                chk("skip_sel", 32'(ROMINIT_SEL), 32'h0);
                chk("skip_busy", 32'(BUSY), 32'h1);
            end
            tick();
            DL_WR = 1'b0;
            tick();
        end
        if (!wr_on_fall) begin
            DL_ACTIVE = 1'b0;
            tick();
        end
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [15:0] sum;
        RES       = 1'b1;
        DL_ACTIVE = 1'b0;
        DL_INDEX  = 8'h0;
        DL_WR     = 1'b0;
        DL_DATA   = 8'h0;
        tick();
        tick();
        // Reset state.
        chk("rst_sel",      32'(ROMINIT_SEL),   32'h0);
        chk("rst_valid",    32'(ROMINIT_VALID), 32'h0);
        chk("rst_addr",     32'(ROMINIT_ADDR),  32'h0);
        chk("rst_data",     32'(ROMINIT_DATA),  32'h0);
        chk("rst_loaded",   32'(LOADED),        32'h0);
        chk("rst_overflow", 32'(OVERFLOW),      32'h0);
        chk("rst_busy",     32'(BUSY),          32'h0);
        RES = 1'b0;
        tick();

        // DL_WR in IDLE is ignored.
        DL_WR = 1'b1; DL_DATA = 8'h77;
        tick();
        DL_WR = 1'b0;
        tick();
        tick();

        // Channel 0: 16 bytes 0x00..0x0F.
        for (int k = 0; k < 16; k++) pat[k] = 8'(k);
        download(int'(ROMIDX_BOOT), 16, 1'b0);
        chk("boot_loaded",   32'(LOADED),      32'h1);
        chk("boot_overflow", 32'(OVERFLOW),    32'h0);
        chk("boot_sel_off",  32'(ROMINIT_SEL), 32'h0);
        chk("boot_busy_off", 32'(BUSY),        32'h0);

        // Channel 2 capacity 8, 10 bytes: two dropped.
        for (int k = 0; k < 10; k++) pat[k] = 8'(8'h40 + k);
        download(int'(ROMIDX_APU), 10, 1'b0);
        chk("apu_overflow", 32'(OVERFLOW), 32'h4);
        chk("apu_loaded",   32'(LOADED),   32'h5);

        // Out-of-range index 9: no writes, busy until the fall.
        for (int k = 0; k < 4; k++) pat[k] = 8'(8'hC0 + k);
        download(9, 4, 1'b0);
        chk("skip_busy_off", 32'(BUSY),   32'h0);
        chk("skip_loaded",   32'(LOADED), 32'h5);

        // Channel 1: 5th byte 0xA5 strobed as DL_ACTIVE falls.
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'hA5;
        download(int'(ROMIDX_CHR), 5, 1'b1);
        chk("fall_loaded", 32'(LOADED), 32'h7);

        // Reload channel 0: addresses restart at 0, LOADED stays set.
        pat[0] = 8'h5A; pat[1] = 8'h5B; pat[2] = 8'h5C;
        download(int'(ROMIDX_BOOT), 3, 1'b0);
        chk("reload_loaded", 32'(LOADED), 32'h7);

        // Channel 3: reset after 3 bytes with the download still active.
        DL_INDEX  = 8'(ROMIDX_CART);
        DL_ACTIVE = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            DL_WR   = 1'b1;
            DL_DATA = 8'(8'hE0 + k);
            e.sel = 4'b1000; e.addr = AW'(k); e.data = DL_DATA;
            exp_q.push_back(e);
            tick();
            DL_WR = 1'b0;
            tick();
        end
        chk("abort_busy_before", 32'(BUSY), 32'h1);
        RES = 1'b1;
        tick();
        chk("abort_sel",    32'(ROMINIT_SEL),   32'h0);
        chk("abort_valid",  32'(ROMINIT_VALID), 32'h0);
        chk("abort_addr",   32'(ROMINIT_ADDR),  32'h0);
        chk("abort_loaded", 32'(LOADED),        32'h0);
        chk("abort_busy",   32'(BUSY),          32'h0);
        RES = 1'b0;
        tick();
        // Still active after reset: strobes must be ignored.
        for (int k = 0; k < 2; k++) begin
            DL_WR = 1'b1; DL_DATA = 8'hEE;
            tick();
            DL_WR = 1'b0;
            tick();
        end
        chk("abort_idle_busy", 32'(BUSY), 32'h0);
        DL_ACTIVE = 1'b0;
        tick();
        tick();
        pat[0] = 8'h01; pat[1] = 8'h02;
        download(int'(ROMIDX_CART), 2, 1'b0);
        chk("cart_loaded", 32'(LOADED), 32'h8);

`ifdef ROMINIT_CHECKSUM_EN
        // Channel 1: 258 bytes of 0xFF.
        sum = 16'h0;
        for (int k = 0; k < 258; k++) begin
            pat[k] = 8'hFF;
            sum    = sum + 16'(pat[k]);
        end
        download(int'(ROMIDX_CHR), 258, 1'b0);
        chk("cksum_chr", 32'(cksum[1]), 32'(sum));
        chk("cksum_loaded", 32'(LOADED[1]), 32'h1);
`else
        sum = 16'h0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
